// File: rtl/ham_stream_encoder_if.sv
// Stream bundle for the Hamming encoder: input handshake, codeword output and delivered-word count.
// The codeword width grows by one overall-parity bit when HAM_SECDED_EN is defined.
interface ham_stream_encoder_if #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 16
);

  function automatic int calc_par_w(input int dw);
    int r;
    r = 1;
    for (int i = 0; i < 16; i++) begin
      if ((1 << r) < dw + r + 1) r = r + 1;
    end
    return r;
  endfunction

  localparam int PAR_W = calc_par_w(DATA_W);
`ifdef HAM_SECDED_EN
  localparam int CW_W = DATA_W + PAR_W + 1;
`else
  localparam int CW_W = DATA_W + PAR_W;
`endif

  logic [DATA_W-1:0] data;
  logic              in_valid;
  logic              in_ready;
  logic [CW_W-1:0]   enc_ham_data;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  enc_cnt;

  // master is the environment around the encoder; slave is the encoder itself
  modport master (
    output data, in_valid, out_ready,
    input  in_ready, enc_ham_data, out_valid, enc_cnt
  );

  modport slave (
    input  data, in_valid, out_ready,
    output in_ready, enc_ham_data, out_valid, enc_cnt
  );

endinterface

// File: rtl/ham_stream_encoder.sv
// Single-stage Hamming encoder with valid/ready handshake and a delivered-codeword counter.
// Define HAM_SECDED_EN to append an even overall-parity bit (SECDED codeword).
module ham_stream_encoder #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 16
) (
  input logic clk,
  input logic rst,
  ham_stream_encoder_if.slave bus
);

  function automatic int calc_par_w(input int dw);
    int r;
    r = 1;
    for (int i = 0; i < 16; i++) begin
      if ((1 << r) < dw + r + 1) r = r + 1;
    end
    return r;
  endfunction

  localparam int PAR_W = calc_par_w(DATA_W);
  localparam int HAM_W = DATA_W + PAR_W;
`ifdef HAM_SECDED_EN
  localparam int CW_W = HAM_W + 1;
`else
  localparam int CW_W = HAM_W;
`endif

  logic [HAM_W-1:0] ham;
  logic [CW_W-1:0]  cw;

  logic [CW_W-1:0]  enc_d, enc_q;
  logic             out_valid_d, out_valid_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             in_ready;
  logic             accept;
  logic             xfer;

  // Scatter data into non-power-of-two positions, then fold each parity group
  always_comb begin
    int di;
    ham = '0;
    di  = 0;
    for (int p = 1; p <= HAM_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        ham[p-1] = bus.data[di];
        di = di + 1;
      end
    end
    for (int k = 0; k < PAR_W; k++) begin
      for (int p = 1; p <= HAM_W; p++) begin
        if ((((p >> k) & 1) != 0) && ((p & (p - 1)) != 0)) begin
          ham[(1 << k) - 1] = ham[(1 << k) - 1] ^ ham[p-1];
        end
      end
    end
  end

`ifdef HAM_SECDED_EN
  assign cw = {^ham, ham};
`else
  assign cw = ham;
`endif

  always_comb begin
    in_ready    = !out_valid_q || bus.out_ready;
    accept      = bus.in_valid && in_ready;
    xfer        = out_valid_q && bus.out_ready;
    enc_d       = enc_q;
    out_valid_d = out_valid_q;
    cnt_d       = cnt_q;
    if (accept) begin
      enc_d       = cw;
      out_valid_d = 1'b1;
    end else if (xfer) begin
      out_valid_d = 1'b0;
    end
    if (xfer) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enc_q       <= '0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      enc_q       <= enc_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.enc_ham_data = enc_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.enc_cnt      = cnt_q;

endmodule

// File: tb/tb_ham_stream_encoder.sv
// Directed bench for ham_stream_encoder: a DATA_W=4 instance for handshake/reset/codeword
// vectors and a DATA_W=11, CNT_W=4 instance for exhaustive syndrome and counter-wrap checks.
module tb_ham_stream_encoder;

`ifdef HAM_SECDED_EN
  localparam int CW_A = 8;
  localparam int CW_B = 16;
`else
  localparam int CW_A = 7;
  localparam int CW_B = 15;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  ham_stream_encoder_if #(.DATA_W(4),  .CNT_W(16)) bus_a ();
  ham_stream_encoder_if #(.DATA_W(11), .CNT_W(4))  bus_b ();

  ham_stream_encoder #(.DATA_W(4), .CNT_W(16)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  ham_stream_encoder #(.DATA_W(11), .CNT_W(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  logic [3:0] burst_data [10] = '{4'hB, 4'h1, 4'h2, 4'h4, 4'h8, 4'hF, 4'h0, 4'h6, 4'h9, 4'hC};
`ifdef HAM_SECDED_EN
  logic [7:0] burst_exp [10] = '{8'h55, 8'h87, 8'h99, 8'hAA, 8'h4B, 8'hFF, 8'h00, 8'h33, 8'hCC, 8'hE1};
`else
  logic [7:0] burst_exp [10] = '{8'h55, 8'h07, 8'h19, 8'h2A, 8'h4B, 8'h7F, 8'h00, 8'h33, 8'h4C, 8'h61};
`endif

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Syndrome over Hamming positions 1..15: XOR of the positions of all set bits
  function automatic logic [3:0] syn15(input logic [14:0] c);
    logic [3:0] s;
    s = 4'd0;
    for (int i = 0; i < 15; i++) begin
      if (c[i]) s = s ^ 4'(i + 1);
    end
    return s;
  endfunction

  initial begin
    logic [CW_B-1:0] cw_b;
    logic [14:0]     flipped;

    rst = 1'b1;
    bus_a.data = '0; bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b0;
    bus_b.data = '0; bus_b.in_valid = 1'b0; bus_b.out_ready = 1'b0;
    #3;
    checkOutput("reset_out_valid", 32'(bus_a.out_valid), 32'd0);
    checkOutput("reset_enc_data", 32'(bus_a.enc_ham_data), 32'd0);
    checkOutput("reset_enc_cnt", 32'(bus_a.enc_cnt), 32'd0);
    checkOutput("reset_in_ready", 32'(bus_a.in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // first accept with downstream stalled
    bus_a.data = 4'b1011; bus_a.in_valid = 1'b1; bus_a.out_ready = 1'b0;
    tick();
    checkOutput("first_out_valid", 32'(bus_a.out_valid), 32'd1);
    checkOutput("first_codeword_1011", 32'(bus_a.enc_ham_data), 32'h55);
    checkOutput("first_enc_cnt", 32'(bus_a.enc_cnt), 32'd0);

    // three stalled cycles with a new word waiting
    bus_a.data = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      checkOutput("stall_in_ready", 32'(bus_a.in_ready), 32'd0);
      tick();
      checkOutput("stall_out_valid", 32'(bus_a.out_valid), 32'd1);
      checkOutput("stall_codeword_held", 32'(bus_a.enc_ham_data), 32'h55);
      checkOutput("stall_enc_cnt", 32'(bus_a.enc_cnt), 32'd0);
    end

    bus_a.out_ready = 1'b1;
    #1;
    checkOutput("release_in_ready", 32'(bus_a.in_ready), 32'd1);
    tick();
    checkOutput("release_out_valid", 32'(bus_a.out_valid), 32'd1);
`ifdef HAM_SECDED_EN
    checkOutput("codeword_0001", 32'(bus_a.enc_ham_data), 32'h87);
`else
    checkOutput("codeword_0001", 32'(bus_a.enc_ham_data), 32'h07);
`endif
    checkOutput("release_enc_cnt", 32'(bus_a.enc_cnt), 32'd1);

    bus_a.in_valid = 1'b0;
    tick();
    checkOutput("drain_out_valid", 32'(bus_a.out_valid), 32'd0);
    checkOutput("drain_enc_cnt", 32'(bus_a.enc_cnt), 32'd2);
`ifdef HAM_SECDED_EN
    checkOutput("drain_codeword_kept", 32'(bus_a.enc_ham_data), 32'h87);
`else
    checkOutput("drain_codeword_kept", 32'(bus_a.enc_ham_data), 32'h07);
`endif

    // reset between edges with a codeword pending
    bus_a.data = 4'b0110; bus_a.in_valid = 1'b1; bus_a.out_ready = 1'b0;
    tick();
    checkOutput("pending_codeword_0110", 32'(bus_a.enc_ham_data), 32'h33);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_out_valid", 32'(bus_a.out_valid), 32'd0);
    checkOutput("async_rst_enc_data", 32'(bus_a.enc_ham_data), 32'd0);
    checkOutput("async_rst_enc_cnt", 32'(bus_a.enc_cnt), 32'd0);
    checkOutput("async_rst_in_ready", 32'(bus_a.in_ready), 32'd1);
    tick();
    checkOutput("rst_no_accept_valid", 32'(bus_a.out_valid), 32'd0);
    checkOutput("rst_no_accept_data", 32'(bus_a.enc_ham_data), 32'd0);
    #2;
    rst = 1'b0;
    bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b1;
    tick();
    checkOutput("post_rst_out_valid", 32'(bus_a.out_valid), 32'd0);
    checkOutput("post_rst_enc_cnt", 32'(bus_a.enc_cnt), 32'd0);

    // ten back-to-back words with downstream always ready
    for (int i = 0; i < 10; i++) begin
      bus_a.data = burst_data[i]; bus_a.in_valid = 1'b1;
      tick();
      checkOutput("burst_out_valid", 32'(bus_a.out_valid), 32'd1);
      checkOutput("burst_codeword", 32'(bus_a.enc_ham_data), 32'(burst_exp[i][CW_A-1:0]));
      checkOutput("burst_enc_cnt", 32'(bus_a.enc_cnt), 32'(i));
    end
    bus_a.in_valid = 1'b0;
    tick();
    checkOutput("burst_final_valid", 32'(bus_a.out_valid), 32'd0);
    checkOutput("burst_final_cnt", 32'(bus_a.enc_cnt), 32'd10);

    // exhaustive DATA_W=11: every single-bit flip must be located by the syndrome
    bus_b.out_ready = 1'b1;
    for (int v = 0; v < 2048; v++) begin
      bus_b.data = 11'(v); bus_b.in_valid = 1'b1;
      tick();
      cw_b = bus_b.enc_ham_data;
      checkOutput("b11_out_valid", 32'(bus_b.out_valid), 32'd1);
      checkOutput("b11_data_positions", 32'({cw_b[14:8], cw_b[6:4], cw_b[2]}), 32'(v));
      checkOutput("b11_clean_syndrome", 32'(syn15(cw_b[14:0])), 32'd0);
`ifdef HAM_SECDED_EN
      checkOutput("b11_overall_parity", 32'(^cw_b), 32'd0);
`endif
      for (int j = 0; j < 15; j++) begin
        flipped = cw_b[14:0] ^ (15'd1 << j);
        checkOutput("b11_flip_syndrome", 32'(syn15(flipped)), 32'(j + 1));
      end
    end
    bus_b.in_valid = 1'b0;
    tick();
    checkOutput("b11_drain_valid", 32'(bus_b.out_valid), 32'd0);
    checkOutput("b11_cnt_wrap_2048", 32'(bus_b.enc_cnt), 32'd0);

    // counter wrap: 17 transfers on a 4-bit counter
    #2;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    for (int i = 0; i < 17; i++) begin
      bus_b.data = 11'(i * 37); bus_b.in_valid = 1'b1;
      tick();
    end
    bus_b.in_valid = 1'b0;
    tick();
    checkOutput("b11_cnt_wrap_17", 32'(bus_b.enc_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
